// File: rtl/param_simple_processor_if.sv
// Handshake/bus bundle for param_simple_processor: instruction request,
// instruction/immediate word, observable bus, completion strobe and flags.
interface param_simple_processor_if #(
  parameter int WIDTH = 9
);
  logic             Run;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] Bus;
  logic             Done;
  logic             Zflag;
  logic             Cflag;

  modport master (
    output Run,
    output DIN,
    input  Bus,
    input  Done,
    input  Zflag,
    input  Cflag
  );

  modport slave (
    input  Run,
    input  DIN,
    output Bus,
    output Done,
    output Zflag,
    output Cflag
  );
endinterface

// File: rtl/param_simple_processor.sv
// Small multi-cycle processor: eight general registers, accumulator A,
// result register G and a 9-bit instruction register. Moves complete in
// T1; ALU operations go through T1 (latch X into A), T2 (compute into G and
// update flags) and T3 (write G back to X). Every transfer goes over Bus.
module param_simple_processor #(
  parameter int WIDTH = 9
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  param_simple_processor_if.slave io
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MVNZ = 3'b111
  } opcode_t;

  state_t           state_q, state_d;
  logic [8:0]       ir_q;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic             z_q;
  logic             c_q;

  opcode_t          op;
  logic [2:0]       rx;
  logic [2:0]       ry;

  logic [WIDTH-1:0] busVal;
  logic             doneVal;
  logic             irLoad;
  logic             rxWrite;
  logic             aLoad;
  logic             gLoad;

  logic [WIDTH:0]   sumFull;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             carryUpd;

  assign op = opcode_t'(ir_q[8:6]);
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // State register; reset always returns the sequencer to fetch.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, bus driver selection and register-enable decode.
  always_comb begin
    state_d = state_q;
    busVal  = '0;
    doneVal = 1'b0;
    irLoad  = 1'b0;
    rxWrite = 1'b0;
    aLoad   = 1'b0;
    gLoad   = 1'b0;
    case (state_q)
      T0: begin
        if (io.Run) begin
          irLoad  = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            busVal  = regs_q[ry];
            rxWrite = 1'b1;
            doneVal = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            busVal  = io.DIN;
            rxWrite = 1'b1;
            doneVal = 1'b1;
            state_d = T0;
          end
          OP_MVNZ: begin
            busVal  = regs_q[ry];
            rxWrite = (g_q != '0);
            doneVal = 1'b1;
            state_d = T0;
          end
          default: begin
            busVal  = regs_q[rx];
            aLoad   = 1'b1;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        busVal  = regs_q[ry];
        gLoad   = 1'b1;
        state_d = T3;
      end
      T3: begin
        busVal  = g_q;
        rxWrite = 1'b1;
        doneVal = 1'b1;
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  // ALU: A against the bus (RY in T2); carry only meaningful for add/sub.
  always_comb begin
    sumFull  = {1'b0, a_q} + {1'b0, busVal};
    aluRes   = '0;
    aluCarry = 1'b0;
    carryUpd = 1'b0;
    case (op)
      OP_ADD: begin
        aluRes   = sumFull[WIDTH-1:0];
        aluCarry = sumFull[WIDTH];
        carryUpd = 1'b1;
      end
      OP_SUB: begin
        aluRes   = a_q - busVal;
        aluCarry = (a_q >= busVal);
        carryUpd = 1'b1;
      end
      OP_AND:  aluRes = a_q & busVal;
      OP_OR:   aluRes = a_q | busVal;
      OP_XOR:  aluRes = a_q ^ busVal;
      default: aluRes = '0;
    endcase
  end

  // Datapath registers: IR, register file, A, G and the flags.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      a_q <= '0;
      g_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      if (irLoad) begin
        ir_q <= io.DIN[8:0];
      end
      if (rxWrite) begin
        regs_q[rx] <= busVal;
      end
      if (aLoad) begin
        a_q <= busVal;
      end
      if (gLoad) begin
        g_q <= aluRes;
        z_q <= (aluRes == '0);
        if (carryUpd) begin
          c_q <= aluCarry;
        end
      end
    end
  end

  assign io.Bus   = busVal;
  assign io.Done  = doneVal;
  assign io.Zflag = z_q;
  assign io.Cflag = c_q;

endmodule

// File: doc/param_simple_processor.md
PARAM_SIMPLE_PROCESSOR -- requirements
Module: param_simple_processor

Interface
REQ-001 Parameter WIDTH, default 9, sets the data/register/bus width; legal range 9..32.
REQ-002 Port Clock  input  1  rising-edge clock.
REQ-003 Port Resetn  input  1  asynchronous, active-low reset.
REQ-004 Port Run  input  1  start-instruction request; sampled only in state T0.
REQ-005 Port DIN  input  WIDTH  instruction word (bits [8:0]) or immediate data.
REQ-006 Port Bus  output  WIDTH  internal bus value, observable every cycle.
REQ-007 Port Done  output  1  high for exactly the final cycle of each instruction.
REQ-008 Port Zflag  output  1  registered zero flag of the last ALU result.
REQ-009 Port Cflag  output  1  registered carry/no-borrow flag of the last add/sub.

Function
REQ-010 Eight WIDTH-bit registers R0..R7, an accumulator A, a result register G and a 9-bit IR shall exist.
REQ-011 Instruction encoding: III=IR[8:6], XXX=IR[5:3], YYY=IR[2:0]; DIN bits above [8] are ignored when loading IR.
REQ-012 Opcodes: 000 mv RX<-RY; 001 mvi RX<-DIN; 010 add; 011 sub; 100 and; 101 or; 110 xor; 111 mvnz (RX<-RY only if G!=0).
REQ-013 FSM states T0, T1, T2, T3; T0 is the idle/fetch state.
REQ-014 T0: if Run=1, IR<=DIN[8:0] and go to T1; otherwise remain in T0 with IR unchanged.
REQ-015 T1, mv: Bus=RY, RX<=Bus, Done=1, next state T0.
REQ-016 T1, mvi: Bus=DIN, RX<=DIN, Done=1, next state T0; the immediate is the DIN value present in the cycle after the opcode.
REQ-017 T1, mvnz: Bus=RY, RX<=Bus only when G!=0, Done=1, next state T0.
REQ-018 T1, ALU ops: Bus=RX, A<=Bus, next state T2.
REQ-019 T2, ALU ops: Bus=RY, G<=A op Bus, computed modulo 2^WIDTH; Zflag and Cflag shall update in this same cycle.
REQ-020 Flags: Zflag<=(result==0) for all ALU ops; Cflag<=carry-out for add and <=(A>=RY unsigned) for sub; Cflag is held unchanged for and/or/xor.
REQ-021 T3: Bus=G, RX<=G, Done=1, next state T0.
REQ-022 Latency: mv, mvi and mvnz take 2 cycles including fetch; ALU ops take 4 cycles.
REQ-023 Bus shall be 0 in any cycle with no selected driver (T0).
REQ-024 Done shall be combinational from state and IR, and low in every other cycle.
REQ-025 Run deasserted mid-instruction shall not abort it; the instruction completes and the FSM then idles in T0.
REQ-026 Run held high shall fetch the next instruction in the cycle immediately after Done, with no idle gap.
REQ-027 When X==Y, the ALU ops use the same register for both operands (e.g. sub R0,R0 gives 0).

Reset
REQ-028 Resetn=0 shall asynchronously clear R0..R7, A, G, IR, Zflag and Cflag, and force state T0; Done=0 and Bus=0.
REQ-029 Reset asserted mid-instruction shall abort it with no register write; after release, the FSM waits in T0 for Run.

Verification
REQ-030 Reset with WIDTH=9: all registers and flags are 0 and Done=0; Run=0 for 5 cycles leaves state in T0 and Bus=0.
REQ-031 mvi: DIN=001_000_000 then 0x1F0 gives R0=0x1F0 and Done high only in the second cycle; the same sequence loads R2=0x1FF.
REQ-032 sub R0,R2 (011_000_010) with R0=0x1F0 and R2=0x1FF: at T3 Bus=0x1F1 and R0=0x1F1, with Zflag=0 and Cflag=0; Done is high only on cycle 4.
REQ-033 sub R0,R0 gives R0=0, Zflag=1 and Cflag=1; then mvnz R1,R2 leaves R1 unchanged; after add making G!=0, mvnz copies R2 into R1.
REQ-034 WIDTH=16: R3=0xFFFF, R4=1, add R3,R4 gives R3=0x0000, Zflag=1 and Cflag=1; and/or/xor on 0xA5A5 and 0x0FF0 give 0x05A0, 0xAFF5 and 0xAA55 with Cflag held.
REQ-035 Resetn pulsed low during T2 of an add: registers return to 0, Done is never asserted, and the next instruction executes normally from T0.
